// File: rtl/axi2per_pkg.sv
// Shared types and constants for the AXI-to-peripheral burst request channel.
// AXI2PER_WRAP_BURST_EN (see axi2per_addr_gen) enables true WRAP bursts.
package axi2per_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RD_BURST  = 2'd1,
      WR_BURST  = 2'd2,
      WAIT_RESP = 2'd3
   } state_e;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // Every peripheral beat moves one 32-bit word.
   localparam int PER_BEAT_BYTES = 4;

endpackage

// File: rtl/axi2per_addr_gen.sv
// Next-beat address generator for FIXED / INCR / WRAP bursts.
// Macro AXI2PER_WRAP_BURST_EN: when undefined, WRAP behaves as INCR.
module axi2per_addr_gen
   import axi2per_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32
) (
   input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
   input  logic [7:0]                len_i,
   input  logic [2:0]                size_i,
   input  logic [1:0]                burst_i,
   output logic [AXI_ADDR_WIDTH-1:0] next_addr_o
);

   localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(PER_BEAT_BYTES);

   logic [AXI_ADDR_WIDTH-1:0] incr_addr_s;
   logic                      unused_s;

   assign incr_addr_s = addr_i + BEAT_BYTES;
   // Peripheral beats are always one word wide, so size does not affect the step.
   assign unused_s    = ^{size_i, len_i};

`ifdef AXI2PER_WRAP_BURST_EN
   logic [AXI_ADDR_WIDTH-1:0] wrap_mask_s;
   assign wrap_mask_s = ((AXI_ADDR_WIDTH'(len_i) + AXI_ADDR_WIDTH'(1)) * BEAT_BYTES)
                        - AXI_ADDR_WIDTH'(1);
`endif

   // Select the next address according to the latched burst type.
   always_comb begin
      next_addr_o = incr_addr_s;
      case (burst_i)
         BURST_FIXED: next_addr_o = addr_i;
         BURST_INCR:  next_addr_o = incr_addr_s;
         BURST_WRAP: begin
`ifdef AXI2PER_WRAP_BURST_EN
            next_addr_o = (addr_i & ~wrap_mask_s) | (incr_addr_s & wrap_mask_s);
`else
            next_addr_o = incr_addr_s;
`endif
         end
         default:     next_addr_o = incr_addr_s;
      endcase
   end

endmodule

// File: rtl/axi2per_burst_req_channel.sv
// Accepts AXI AR/AW bursts and replays them beat by beat on a 32-bit peripheral port.
// Macro AXI2PER_WRAP_BURST_EN (in axi2per_addr_gen) enables true WRAP address wrapping.
module axi2per_burst_req_channel
   import axi2per_pkg::*;
#(
   parameter int PER_ADDR_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,

   input  logic                        axi_slave_aw_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr_i,
   input  logic [7:0]                  axi_slave_aw_len_i,
   input  logic [2:0]                  axi_slave_aw_size_i,
   input  logic [1:0]                  axi_slave_aw_burst_i,
   input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id_i,
   output logic                        axi_slave_aw_ready_o,

   input  logic                        axi_slave_ar_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr_i,
   input  logic [7:0]                  axi_slave_ar_len_i,
   input  logic [2:0]                  axi_slave_ar_size_i,
   input  logic [1:0]                  axi_slave_ar_burst_i,
   input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id_i,
   output logic                        axi_slave_ar_ready_o,

   input  logic                        axi_slave_w_valid_i,
   input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data_i,
   input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb_i,
   input  logic                        axi_slave_w_last_i,
   output logic                        axi_slave_w_ready_o,

   output logic                        per_master_req_o,
   output logic [PER_ADDR_WIDTH-1:0]   per_master_add_o,
   output logic                        per_master_we_o,
   output logic [31:0]                 per_master_wdata_o,
   output logic [3:0]                  per_master_be_o,
   input  logic                        per_master_gnt_i,

   output logic                        trans_req_o,
   output logic                        trans_we_o,
   output logic [AXI_ID_WIDTH-1:0]     trans_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]   trans_add_o,
   output logic [7:0]                  trans_len_o,
   input  logic                        trans_r_valid_i
);

   localparam int         AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
   localparam int         NUM_LANES      = AXI_DATA_WIDTH / 32;
   localparam logic [1:0] LANE_MASK      = 2'(NUM_LANES - 1);

   state_e                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                len_q, len_d;
   logic [2:0]                size_q, size_d;
   logic [1:0]                burst_q, burst_d;
   logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
   logic [7:0]                cnt_q, cnt_d;
   logic                      last_rd_q, last_rd_d;

   logic [AXI_ADDR_WIDTH-1:0] next_addr_s;
   logic [1:0]                lane_s;
   logic [6:0]                data_shift_s;
   logic [4:0]                strb_shift_s;
   logic                      rd_wins_s;
   logic                      unused_s;

   axi2per_addr_gen #(
      .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH)
   ) u_addr_gen (
      .addr_i      (addr_q),
      .len_i       (len_q),
      .size_i      (size_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr_s)
   );

   // The beat counter alone ends a burst, so WLAST carries no information here.
   assign unused_s     = axi_slave_w_last_i;
   assign lane_s       = addr_q[3:2] & LANE_MASK;
   assign data_shift_s = {lane_s, 5'b00000};
   assign strb_shift_s = {1'b0, lane_s, 2'b00};
   assign rd_wins_s    = axi_slave_ar_valid_i & (~axi_slave_aw_valid_i | ~last_rd_q);

   // State and latched burst registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         len_q     <= 8'd0;
         size_q    <= 3'd0;
         burst_q   <= 2'd0;
         id_q      <= '0;
         cnt_q     <= 8'd0;
         last_rd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
         last_rd_q <= last_rd_d;
      end
   end

   // Arbitration, beat sequencing and all output drive.
   always_comb begin
      state_d              = state_q;
      addr_d               = addr_q;
      len_d                = len_q;
      size_d               = size_q;
      burst_d              = burst_q;
      id_d                 = id_q;
      cnt_d                = cnt_q;
      last_rd_d            = last_rd_q;

      axi_slave_aw_ready_o = 1'b0;
      axi_slave_ar_ready_o = 1'b0;
      axi_slave_w_ready_o  = 1'b0;
      per_master_req_o     = 1'b0;
      per_master_add_o     = '0;
      per_master_we_o      = 1'b0;
      per_master_wdata_o   = 32'd0;
      per_master_be_o      = 4'd0;
      trans_req_o          = 1'b0;
      trans_we_o           = 1'b0;
      trans_id_o           = '0;
      trans_add_o          = '0;
      trans_len_o          = 8'd0;

      case (state_q)
         IDLE: begin
            // Acceptance is blocked while reset is held so no ready leaks out.
            if (rst_ni && rd_wins_s) begin
               axi_slave_ar_ready_o = 1'b1;
               addr_d      = axi_slave_ar_addr_i;
               len_d       = axi_slave_ar_len_i;
               size_d      = axi_slave_ar_size_i;
               burst_d     = axi_slave_ar_burst_i;
               id_d        = axi_slave_ar_id_i;
               cnt_d       = 8'd0;
               last_rd_d   = 1'b1;
               state_d     = RD_BURST;
               trans_req_o = 1'b1;
               trans_we_o  = 1'b1;
               trans_id_o  = axi_slave_ar_id_i;
               trans_add_o = axi_slave_ar_addr_i;
               trans_len_o = axi_slave_ar_len_i;
            end else if (rst_ni && axi_slave_aw_valid_i) begin
               axi_slave_aw_ready_o = 1'b1;
               addr_d      = axi_slave_aw_addr_i;
               len_d       = axi_slave_aw_len_i;
               size_d      = axi_slave_aw_size_i;
               burst_d     = axi_slave_aw_burst_i;
               id_d        = axi_slave_aw_id_i;
               cnt_d       = 8'd0;
               last_rd_d   = 1'b0;
               state_d     = WR_BURST;
               trans_req_o = 1'b1;
               trans_we_o  = 1'b0;
               trans_id_o  = axi_slave_aw_id_i;
               trans_add_o = axi_slave_aw_addr_i;
               trans_len_o = axi_slave_aw_len_i;
            end else begin
               state_d = IDLE;
            end
         end

         RD_BURST: begin
            per_master_req_o = 1'b1;
            per_master_we_o  = 1'b1;
            per_master_add_o = PER_ADDR_WIDTH'(addr_q);
            if (per_master_gnt_i) begin
               addr_d = next_addr_s;
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == len_q) begin
                  state_d = WAIT_RESP;
               end else begin
                  state_d = RD_BURST;
               end
            end else begin
               state_d = RD_BURST;
            end
         end

         WR_BURST: begin
            per_master_add_o = PER_ADDR_WIDTH'(addr_q);
            if (axi_slave_w_valid_i) begin
               per_master_req_o   = 1'b1;
               per_master_wdata_o = 32'(axi_slave_w_data_i >> data_shift_s);
               per_master_be_o    = 4'(axi_slave_w_strb_i >> strb_shift_s);
               if (per_master_gnt_i) begin
                  axi_slave_w_ready_o = 1'b1;
                  addr_d = next_addr_s;
                  cnt_d  = cnt_q + 8'd1;
                  if (cnt_q == len_q) begin
                     state_d = WAIT_RESP;
                  end else begin
                     state_d = WR_BURST;
                  end
               end else begin
                  state_d = WR_BURST;
               end
            end else begin
               state_d = WR_BURST;
            end
         end

         WAIT_RESP: begin
            if (trans_r_valid_i) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_RESP;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/axi2per_burst_req_channel.md
AXI2PER_BURST_REQ_CHANNEL -- requirements
Module: axi2per_burst_req_channel

Interface
REQ-001 SHALL have parameter PER_ADDR_WIDTH, default 32, peripheral address width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 64, AXI data width; legal values are 32, 64 and 128.
REQ-004 SHALL have parameter AXI_ID_WIDTH, default 3, AXI ID width.
REQ-005 SHALL have local parameter AXI_STRB_WIDTH = AXI_DATA_WIDTH/8, not overridable.
REQ-006 SHALL have ports clk_i (in, 1, sole clock) and rst_ni (in, 1, asynchronous active-low reset): one clock; reset is asynchronous and active-low.
REQ-007 SHALL have AW inputs axi_slave_aw_{valid,addr,len,size,burst,id}_i (1/AXI_ADDR_WIDTH/8/3/2/AXI_ID_WIDTH) and output axi_slave_aw_ready_o (1).
REQ-008 SHALL have AR inputs axi_slave_ar_{valid,addr,len,size,burst,id}_i with the same widths, and output axi_slave_ar_ready_o (1).
REQ-009 SHALL have W inputs axi_slave_w_valid_i (1), axi_slave_w_data_i (AXI_DATA_WIDTH), axi_slave_w_strb_i (AXI_STRB_WIDTH) and axi_slave_w_last_i (1), and output axi_slave_w_ready_o (1).
REQ-010 SHALL have peripheral outputs per_master_req_o (1), per_master_add_o (PER_ADDR_WIDTH), per_master_we_o (1, 1=read), per_master_wdata_o (32) and per_master_be_o (4), and input per_master_gnt_i (1).
REQ-011 SHALL have outputs trans_req_o (1), trans_we_o (1), trans_id_o (AXI_ID_WIDTH), trans_add_o (AXI_ADDR_WIDTH) and trans_len_o (8), and input trans_r_valid_i (1, burst complete).

Function
REQ-012 SHALL implement FSM states IDLE, RD_BURST, WR_BURST and WAIT_RESP.
REQ-013 IDLE arbitration:
- Only AR valid, or only AW valid: that channel wins.
- Both valid: round-robin; winner is the channel opposite the last-served one; reset favours read.
REQ-014 On winning, ready SHALL pulse for exactly one cycle and the burst SHALL be latched:
- latched fields: addr, len, size, burst, id
- beat counter cleared
- next state RD_BURST or WR_BURST.
REQ-015 In the same acceptance cycle, trans_req_o SHALL pulse for one cycle with trans_we_o (1=read), trans_id_o, trans_add_o and trans_len_o.
REQ-016 RD_BURST SHALL hold per_master_req_o=1 and per_master_we_o=1 for each beat; each gnt SHALL advance the address and the beat counter.
REQ-017 WR_BURST SHALL assert per_master_req_o only while axi_slave_w_valid_i=1.
- axi_slave_w_ready_o = per_master_gnt_i AND req.
- W valid low mid-burst: req SHALL deassert and all state SHALL hold.
REQ-018 Lane select SHALL use addr[log2(AXI_STRB_WIDTH)-1:2]:
- wdata = 32-bit data lane; be = 4-bit strobe lane.
- AXI_DATA_WIDTH=32 SHALL use lane 0 only.
REQ-019 Address update on each gnt:
- FIXED: unchanged.
- INCR: +4, modulo 2^AXI_ADDR_WIDTH.
- per_master_add_o = low PER_ADDR_WIDTH bits of the current address.
REQ-020 After the beat whose counter equals the latched len is granted, the FSM SHALL move to WAIT_RESP; len=0 gives a single beat.
REQ-021 The beat counter SHALL be authoritative; axi_slave_w_last_i SHALL be ignored for sequencing.
REQ-022 WAIT_RESP SHALL keep all readies and req low, and SHALL go to IDLE on trans_r_valid_i=1.
REQ-023 A trans_r_valid_i received in any state other than WAIT_RESP SHALL be ignored.
REQ-024 Every output SHALL be 0 whenever it is not actively driven by the state logic.

Reset
REQ-025 rst_ni low SHALL immediately, including mid-burst:
- force the FSM to IDLE
- clear the beat counter and latched fields
- set last-served to write (so read is favoured next)
- drive all outputs to 0.

Configuration
REQ-026 With AXI2PER_WRAP_BURST_EN defined, burst=2'b10 (WRAP) SHALL wrap the address within a (len+1)*4-byte aligned window.
REQ-027 Without AXI2PER_WRAP_BURST_EN, WRAP SHALL be treated as INCR.

Structure
REQ-028 Package axi2per_pkg SHALL hold the FSM state enum and the constants BURST_FIXED/INCR/WRAP.
REQ-029 Sub-module axi2per_addr_gen SHALL compute the next beat address from addr, len, size and burst.

Verification
REQ-030 AR addr=0x100, len=3, INCR, gnt always 1 -> 4 reads at 0x100/104/108/10C on consecutive cycles, then WAIT_RESP.
REQ-031 AW addr=0x4, len=0, wdata=0x1122334455667788, strb=0xF0 -> wdata=0x11223344, be=0xF, we=0.
REQ-032 AR and AW valid together in two successive idle windows -> order read, then write; trans_we_o = 1, then 0.
REQ-033 Write len=2 with w_valid low for 2 cycles after beat 0 -> req low 2 cycles, address held, 3 writes total.
REQ-034 With AXI2PER_WRAP_BURST_EN, AR addr=0x18, len=3, WRAP -> addresses 0x18, 0x1C, 0x10, 0x14.
REQ-035 rst_ni low during beat 1 of a len=3 burst -> outputs 0 immediately; next AR restarts at beat 0.
